// File: rtl/key_pkg.sv
// Channel indices, arbiter state encoding and priority helper shared by the button front end and the buzzer top.
package key_pkg;

   localparam int NUM_CH   = 5;
   localparam int CH_DOWN  = 0;
   localparam int CH_LEFT  = 1;
   localparam int CH_MID   = 2;
   localparam int CH_RIGHT = 3;
   localparam int CH_UP    = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } arb_state_t;

   // Highest set index wins: up > right > mid > left > down.
   function automatic logic [2:0] prio_sel(input logic [NUM_CH-1:0] req);
      prio_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (req[i]) prio_sel = 3'(i);
      end
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchroniser, then a level that only follows s2 after DB_CYCLES consecutive disagreeing samples.
// Latency: raw edge sampled at edge k reaches stable after edge k+1+DB_CYCLES; no backpressure.
module debounce_ch #(
   parameter int DB_CYCLES = 1_000_000,
   parameter int CNT_W     = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw,
   output logic stable
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         s1 <= sw;
         s2 <= s1;
         // Any agreement with the current level restarts qualification.
         if (s2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_debounce_arb.sv
// Debounces five buttons, emits per-button press pulses and grants one tone at a time, first arrival wins.
// Latency: outputs one cycle after the debounced level changes; silence gap of one cycle between grants; no backpressure.
module key_debounce_arb
   import key_pkg::*;
#(
   parameter int DB_CYCLES = 1_000_000,
   parameter int CNT_W     = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sw_up,
   input  logic              sw_left,
   input  logic              sw_mid,
   input  logic              sw_right,
   input  logic              sw_down,
   output logic [NUM_CH-1:0] note_en,
   output logic [NUM_CH-1:0] press_pulse,
   output logic              busy
);

   logic [NUM_CH-1:0] sw_raw;
   logic [NUM_CH-1:0] stable;
   logic [NUM_CH-1:0] stable_d;
   arb_state_t        state;
   logic [2:0]        sel;

   assign sw_raw[CH_DOWN]  = sw_down;
   assign sw_raw[CH_LEFT]  = sw_left;
   assign sw_raw[CH_MID]   = sw_mid;
   assign sw_raw[CH_RIGHT] = sw_right;
   assign sw_raw[CH_UP]    = sw_up;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_ch #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .sw     (sw_raw[i]),
         .stable (stable[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_d    <= '0;
         press_pulse <= '0;
      end else begin
         stable_d    <= stable;
         press_pulse <= stable & ~stable_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         sel     <= '0;
         note_en <= '0;
         busy    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|stable) begin
                  sel     <= prio_sel(stable);
                  note_en <= NUM_CH'(1) << prio_sel(stable);
                  busy    <= 1'b1;
                  state   <= ST_HOLD;
               end else begin
                  note_en <= '0;
                  busy    <= 1'b0;
               end
            end
            ST_HOLD: begin
               // Only the granted button's release matters; dropping to IDLE forces the silence gap.
               if (!stable[sel]) begin
                  note_en <= '0;
                  busy    <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               note_en <= '0;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_key_debounce_arb.sv
// Randomised and directed checks of key_debounce_arb against a sample-window reference model.
module tb_key_debounce_arb;

   localparam int DB = 4;
   localparam int CW = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [4:0] sw = 5'h00;
   logic [4:0] note_en;
   logic [4:0] press_pulse;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   key_debounce_arb #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sw_up       (sw[4]),
      .sw_left     (sw[1]),
      .sw_mid      (sw[2]),
      .sw_right    (sw[3]),
      .sw_down     (sw[0]),
      .note_en     (note_en),
      .press_pulse (press_pulse),
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a level is accepted once the last DB synchronised samples all disagree with it.
   logic [4:0] m_s1, m_s2, m_st, m_std;
   logic [4:0] hist [DB];
   logic [4:0] m_note, m_pulse;
   logic       m_hold, m_busy;
   int         m_sel;

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_st = '0; m_std = '0;
      for (int d = 0; d < DB; d++) hist[d] = '0;
      m_note = '0; m_pulse = '0; m_hold = 1'b0; m_busy = 1'b0; m_sel = 0;
   endtask

   task automatic model_step();
      logic [4:0] ost;
      logic       agree;
      if (!rst_n) begin
         model_reset();
         return;
      end
      ost     = m_st;
      m_pulse = ost & ~m_std;
      m_std   = ost;
      if (!m_hold) begin
         if (ost != 0) begin
            for (int c = 0; c < 5; c++) if (ost[c]) m_sel = c;
            m_hold = 1'b1;
            m_note = 5'b00001 << m_sel;
         end else begin
            m_note = '0;
         end
      end else if (!ost[m_sel]) begin
         m_hold = 1'b0;
         m_note = '0;
      end
      m_busy = m_hold;
      for (int d = DB - 1; d > 0; d--) hist[d] = hist[d-1];
      hist[0] = m_s2;
      for (int c = 0; c < 5; c++) begin
         agree = 1'b0;
         for (int d = 0; d < DB; d++) if (hist[d][c] == m_st[c]) agree = 1'b1;
         if (!agree) m_st[c] = ~m_st[c];
      end
      m_s2 = m_s1;
      m_s1 = sw;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("note_en", 32'(note_en), 32'(m_note));
      chk("press_pulse", 32'(press_pulse), 32'(m_pulse));
      chk("busy", 32'(busy), 32'(m_busy));
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      model_reset();
      sw = 5'h1f;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_note", 32'(note_en), 32'h0);
      chk("rst_pulse", 32'(press_pulse), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      run_n(2);
      rst_n = 1'b1;
      for (int i = 1; i <= DB + 3; i++) begin
         cyc();
         if (i == DB + 2) chk("pwrup_before", 32'(note_en), 32'h00);
         if (i == DB + 3) chk("pwrup_grant", 32'(note_en), 32'h10);
      end
      sw = 5'h00;
      run_n(12);

      // Clean press of mid
      sw = 5'b00100;
      for (int i = 1; i <= DB + 4; i++) begin
         cyc();
         if (i == DB + 3) begin
            chk("mid_note", 32'(note_en), 32'h04);
            chk("mid_pulse", 32'(press_pulse), 32'h04);
         end
         if (i == DB + 4) chk("mid_pulse_once", 32'(press_pulse), 32'h00);
      end
      run_n(5);
      sw = 5'b00000;
      for (int i = 1; i <= DB + 3; i++) begin
         cyc();
         if (i == DB + 2) chk("mid_rel_hold", 32'(note_en), 32'h04);
         if (i == DB + 3) chk("mid_rel_drop", 32'(note_en), 32'h00);
      end
      run_n(8);

      // Glitch shorter than the window, then one long enough
      sw = 5'b00010;
      run_n(DB - 1);
      sw = 5'b00000;
      run_n(10);
      chk("glitch_reject", 32'(note_en), 32'h00);
      sw = 5'b00010;
      run_n(DB + 2);
      sw = 5'b00000;
      cyc();
      chk("glitch_accept", 32'(note_en), 32'h02);
      run_n(12);

      // Simultaneous down + right
      sw = 5'b01001;
      run_n(DB + 3);
      chk("simul_note", 32'(note_en), 32'h08);
      chk("simul_pulse", 32'(press_pulse), 32'h09);
      sw = 5'b00001;
      run_n(DB + 3);
      chk("simul_gap", 32'(note_en), 32'h00);
      cyc();
      chk("simul_regrant", 32'(note_en), 32'h01);
      sw = 5'b00000;
      run_n(12);

      // First arrival wins over higher priority
      sw = 5'b00001;
      run_n(DB + 4);
      sw = 5'b10001;
      run_n(DB + 6);
      chk("first_keep", 32'(note_en), 32'h01);
      sw = 5'b10000;
      run_n(DB + 3);
      chk("first_gap", 32'(note_en), 32'h00);
      cyc();
      chk("first_up", 32'(note_en), 32'h10);
      sw = 5'b00000;
      run_n(12);

      // Asynchronous reset while holding left
      sw = 5'b00010;
      run_n(DB + 4);
      chk("hold_left", 32'(note_en), 32'h02);
      #2 rst_n = 1'b0;
      #1;
      chk("async_note", 32'(note_en), 32'h00);
      chk("async_busy", 32'(busy), 32'h00);
      model_reset();
      run_n(2);
      rst_n = 1'b1;
      run_n(DB + 2);
      chk("rearm_wait", 32'(note_en), 32'h00);
      cyc();
      chk("rearm_grant", 32'(note_en), 32'h02);
      sw = 5'b00000;
      run_n(12);

      // Random bouncing buttons
      for (int seg = 0; seg < 300; seg++) begin
         sw = 5'($urandom_range(0, 31) & $urandom_range(0, 31));
         run_n($urandom_range(1, 2 * DB + 4));
      end
      sw = 5'b00000;
      run_n(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
